multi_warp_scheduler: RTL and testbench

- Per-core control block that time-multiplexes up to MAX_WARPS warps of WARP_SIZE lanes through one fetch/decode/execute datapath.
- Holds per-warp PCs and done flags, and selects warps round-robin.
- Sequences the core pipeline states and generates the lane active mask for a partial last warp.
- Sits between the fetcher, decoder, LSUs and per-lane PC units inside a core.

---
 rtl/multi_warp_scheduler_if.sv | 42 ++++
 rtl/multi_warp_scheduler.sv | 159 +++++++++++++++
 tb/tb_multi_warp_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_warp_scheduler_if.sv
// Core-side control bus of the multi-warp scheduler: kernel launch, fetch and LSU handshake, lane PCs.
// Optional divergence_error signal is present only when DIVERGENCE_CHECK_EN is defined.
interface multi_warp_scheduler_if #(
   parameter int WARP_SIZE = 4,
   parameter int MAX_WARPS = 4,
   parameter int PC_BITS   = 8,
   parameter int TC_BITS   = 8
);
   localparam int WID_BITS = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;

   logic                         start;
   logic [TC_BITS-1:0]           thread_count;
   logic                         instruction_ready;
   logic                         decoded_done;
   logic [WARP_SIZE-1:0]         lsu_busy;
   logic [WARP_SIZE*PC_BITS-1:0] next_pc;
   logic                         fetch_enable;
   logic [PC_BITS-1:0]           fetch_pc;
   logic [WID_BITS-1:0]          current_warp_id;
   logic [WARP_SIZE-1:0]         active_mask;
   logic [2:0]                   core_state;
   logic                         done;
`ifdef DIVERGENCE_CHECK_EN
   logic                         divergence_error;
`endif

   modport slave (
      input  start, thread_count, instruction_ready, decoded_done, lsu_busy, next_pc,
      output fetch_enable, fetch_pc, current_warp_id, active_mask, core_state, done
`ifdef DIVERGENCE_CHECK_EN
      , output divergence_error
`endif
   );

   modport master (
      output start, thread_count, instruction_ready, decoded_done, lsu_busy, next_pc,
      input  fetch_enable, fetch_pc, current_warp_id, active_mask, core_state, done
`ifdef DIVERGENCE_CHECK_EN
      , input divergence_error
`endif
   );
endinterface

// File: rtl/multi_warp_scheduler.sv
// Round-robin warp scheduler: per-warp PCs/done flags and the core pipeline FSM.
// Define DIVERGENCE_CHECK_EN to add the sticky divergence_error output.
module multi_warp_scheduler #(
   parameter int WARP_SIZE = 4,
   parameter int MAX_WARPS = 4,
   parameter int PC_BITS   = 8,
   parameter int TC_BITS   = 8
) (
   input logic                    clk,
   input logic                    reset,
   multi_warp_scheduler_if.slave  bus
);
   localparam int WID_BITS  = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;
   localparam int LANE_BITS = $clog2(WARP_SIZE);
   localparam int WCW       = TC_BITS + 1;
   localparam int IW        = WID_BITS + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_REQUEST, S_WAIT, S_EXECUTE, S_UPDATE, S_DONE
   } state_t;

   state_t               state_reg;
   logic [PC_BITS-1:0]   pc_reg [MAX_WARPS];
   logic [MAX_WARPS-1:0] warp_done_reg;
   logic [WID_BITS-1:0]  cur_reg;
   logic [TC_BITS-1:0]   tc_reg;
   logic                 fetch_enable_reg;
   logic                 done_reg;

   logic [WCW-1:0]       warps_raw;
   logic [WCW-1:0]       warps_sat;
   logic [MAX_WARPS-1:0] launch_done;
   logic [MAX_WARPS-1:0] done_after;
   logic [WARP_SIZE-1:0] mask_w;
   logic                 in_kernel;
   logic                 next_found;
   logic [WID_BITS-1:0]  next_warp;
   logic [IW-1:0]        scan_idx;

   assign warps_raw = ({1'b0, bus.thread_count} + WCW'(WARP_SIZE - 1)) >> LANE_BITS;
   assign warps_sat = (warps_raw > WCW'(MAX_WARPS)) ? WCW'(MAX_WARPS) : warps_raw;
   assign in_kernel = (state_reg != S_IDLE) && (state_reg != S_DONE);

   genvar gi;
   generate
      for (gi = 0; gi < MAX_WARPS; gi++) begin : g_warp
         // Warps with no threads start out retired so the round-robin skips them.
         assign launch_done[gi] = (WCW'(gi) >= warps_sat);
      end
      for (gi = 0; gi < WARP_SIZE; gi++) begin : g_lane
         assign mask_w[gi] = in_kernel && ((32'(cur_reg) * WARP_SIZE + gi) < 32'(tc_reg));
      end
   endgenerate

`ifdef DIVERGENCE_CHECK_EN
   logic                 div_reg;
   logic [WARP_SIZE-1:0] lane_diff;
   generate
      for (gi = 0; gi < WARP_SIZE; gi++) begin : g_div
         assign lane_diff[gi] = mask_w[gi] &&
                                (bus.next_pc[gi*PC_BITS +: PC_BITS] != bus.next_pc[PC_BITS-1:0]);
      end
   endgenerate
   assign bus.divergence_error = div_reg;
`else
   logic unused_lane_pcs;
   assign unused_lane_pcs = ^bus.next_pc;
`endif

   assign done_after = warp_done_reg |
                       (bus.decoded_done ? (MAX_WARPS'(1) << cur_reg) : '0);

   // Scan from the farthest candidate back to current+1 so the nearest live warp wins.
   always_comb begin
      next_found = 1'b0;
      next_warp  = cur_reg;
      scan_idx   = '0;
      for (int k = MAX_WARPS; k >= 1; k--) begin
         scan_idx = {1'b0, cur_reg} + IW'(k);
         if (scan_idx >= IW'(MAX_WARPS)) scan_idx = scan_idx - IW'(MAX_WARPS);
         if (!done_after[scan_idx[WID_BITS-1:0]]) begin
            next_found = 1'b1;
            next_warp  = scan_idx[WID_BITS-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= S_IDLE;
         for (int w = 0; w < MAX_WARPS; w++) pc_reg[w] <= '0;
         warp_done_reg    <= '0;
         cur_reg          <= '0;
         tc_reg           <= '0;
         fetch_enable_reg <= 1'b0;
         done_reg         <= 1'b0;
`ifdef DIVERGENCE_CHECK_EN
         div_reg          <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: if (bus.start) begin
               tc_reg <= bus.thread_count;
`ifdef DIVERGENCE_CHECK_EN
               div_reg <= 1'b0;
`endif
               if (warps_sat == '0) begin
                  state_reg <= S_DONE;
                  done_reg  <= 1'b1;
               end else begin
                  for (int w = 0; w < MAX_WARPS; w++) pc_reg[w] <= '0;
                  warp_done_reg    <= launch_done;
                  cur_reg          <= '0;
                  fetch_enable_reg <= 1'b1;
                  state_reg        <= S_FETCH;
               end
            end
            S_FETCH: if (bus.instruction_ready) begin
               fetch_enable_reg <= 1'b0;
               state_reg        <= S_DECODE;
            end
            S_DECODE:  state_reg <= S_REQUEST;
            S_REQUEST: state_reg <= S_WAIT;
            S_WAIT: if ((bus.lsu_busy & mask_w) == '0) state_reg <= S_EXECUTE;
            S_EXECUTE: state_reg <= S_UPDATE;
            S_UPDATE: begin
               warp_done_reg <= done_after;
               // Lane 0 of any scheduled warp always holds a valid thread.
               if (!bus.decoded_done) begin
                  pc_reg[cur_reg] <= bus.next_pc[PC_BITS-1:0];
`ifdef DIVERGENCE_CHECK_EN
                  if (|lane_diff) div_reg <= 1'b1;
`endif
               end
               if (next_found) begin
                  cur_reg          <= next_warp;
                  fetch_enable_reg <= 1'b1;
                  state_reg        <= S_FETCH;
               end else begin
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: if (!bus.start) begin
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.fetch_enable    = fetch_enable_reg;
   assign bus.fetch_pc        = pc_reg[cur_reg];
   assign bus.current_warp_id = cur_reg;
   assign bus.active_mask     = mask_w;
   assign bus.core_state      = state_reg;
   assign bus.done            = done_reg;
endmodule

// File: tb/tb_multi_warp_scheduler.sv
// Randomized self-checking bench for multi_warp_scheduler against a warp-level reference model.
module tb_multi_warp_scheduler;
   localparam int WS = 4;
   localparam int NW = 4;
   localparam int PB = 8;
   localparam int TB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cycles = 0;
   bit   exp_div = 1'b0;

   always #5 clk = ~clk;

   multi_warp_scheduler_if #(.WARP_SIZE(WS), .MAX_WARPS(NW), .PC_BITS(PB), .TC_BITS(TB)) bus ();

   multi_warp_scheduler #(.WARP_SIZE(WS), .MAX_WARPS(NW), .PC_BITS(PB), .TC_BITS(TB)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cycles++;
   endtask

   function automatic logic [WS-1:0] exp_mask(input int w, input int tc);
      logic [WS-1:0] m;
      for (int i = 0; i < WS; i++) m[i] = ((w * WS + i) < tc);
      return m;
   endfunction

   task automatic check_div();
`ifdef DIVERGENCE_CHECK_EN
      check_val("divergence_error", 32'(bus.divergence_error), 32'(exp_div));
`endif
   endtask

   // mode: 0 single RET instruction, zero waits; 1 random; 2 lane 2 busy 5 cycles;
   //       3 divergent lane PCs on first instruction; 4 three-instruction program, zero waits
   task automatic run_kernel(input int tc, input int mode);
      int wc, cur, nxt, d, nb, exp_wait, exp_cycles, guard;
      int pcs [NW];
      int len [NW];
      bit retired [NW];
      logic [WS-1:0] busy [8];
      logic [WS-1:0] m;
      int lane_val [WS];
      bit found, ret;
      wc = (tc + WS - 1) / WS;
      if (wc > NW) wc = NW;
      for (int w = 0; w < NW; w++) begin
         pcs[w] = 0;
         retired[w] = (w >= wc);
         len[w] = (mode == 1) ? int'($urandom_range(1, 3)) : (mode == 4) ? 3 : (mode == 3) ? 4 : 1;
      end
      exp_div = 1'b0;
      cycles = 0;
      bus.thread_count = TB'(tc);
      bus.start = 1'b1;
      tick();
      bus.thread_count = TB'($urandom);
      if (wc == 0) begin
         check_val("zero_tc_state", 32'(bus.core_state), 7);
         check_val("zero_tc_done", 32'(bus.done), 1);
      end else begin
         cur = 0;
         exp_cycles = 1;
         guard = 0;
         while (guard < 64) begin
            guard++;
            m = exp_mask(cur, tc);
            check_val("fetch_state", 32'(bus.core_state), 1);
            check_val("fetch_enable", 32'(bus.fetch_enable), 1);
            check_val("warp_id", 32'(bus.current_warp_id), 32'(cur));
            check_val("fetch_pc", 32'(bus.fetch_pc), 32'(pcs[cur]));
            check_val("active_mask", 32'(bus.active_mask), 32'(m));
            check_val("done_low", 32'(bus.done), 0);
            check_div();
            d = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            for (int i = 0; i < d; i++) begin
               bus.instruction_ready = 1'b0;
               tick();
               check_val("fetch_hold_state", 32'(bus.core_state), 1);
               check_val("fetch_hold_en", 32'(bus.fetch_enable), 1);
               check_val("fetch_hold_pc", 32'(bus.fetch_pc), 32'(pcs[cur]));
            end
            bus.instruction_ready = 1'b1;
            tick();
            bus.instruction_ready = 1'b0;
            check_val("decode_state", 32'(bus.core_state), 2);
            check_val("fetch_en_drop", 32'(bus.fetch_enable), 0);
            tick();
            check_val("request_state", 32'(bus.core_state), 3);
            nb = 0;
            if (mode == 1) begin
               nb = $urandom_range(0, 4);
               for (int j = 0; j < nb; j++) busy[j] = WS'($urandom);
            end else if (mode == 2) begin
               nb = 5;
               for (int j = 0; j < nb; j++) busy[j] = 4'b0100;
            end
            exp_wait = 1;
            for (int j = 0; j < nb; j++) begin
               if ((busy[j] & m) == '0) break;
               exp_wait++;
            end
            for (int j = 0; j < exp_wait; j++) begin
               tick();
               check_val("wait_state", 32'(bus.core_state), 4);
               bus.lsu_busy = (j < nb) ? busy[j] : '0;
            end
            tick();
            bus.lsu_busy = '0;
            check_val("execute_state", 32'(bus.core_state), 5);
            tick();
            check_val("update_state", 32'(bus.core_state), 6);
            ret = (pcs[cur] == len[cur] - 1);
            for (int i = 0; i < WS; i++) begin
               if (m[i]) lane_val[i] = (pcs[cur] + 1) & 8'hFF;
               else lane_val[i] = $urandom_range(0, 255);
            end
            if (mode == 3 && pcs[cur] == 0) begin
               lane_val[0] = 3; lane_val[1] = 3; lane_val[2] = 7; lane_val[3] = 3;
            end
            bus.decoded_done = ret;
            for (int i = 0; i < WS; i++) bus.next_pc[i*PB +: PB] = PB'(lane_val[i]);
            if (ret) retired[cur] = 1'b1;
            else begin
               for (int i = 0; i < WS; i++)
                  if (m[i] && lane_val[i] != lane_val[0]) exp_div = 1'b1;
               pcs[cur] = lane_val[0];
            end
            found = 1'b0;
            nxt = cur;
            for (int k = 1; k <= NW; k++) begin
               if (!found && !retired[(cur + k) % NW]) begin
                  found = 1'b1;
                  nxt = (cur + k) % NW;
               end
            end
            exp_cycles += d + exp_wait + 5;
            tick();
            bus.decoded_done = 1'b0;
            bus.next_pc = {WS{PB'($urandom)}};
            check_div();
            if (!found) begin
               check_val("done_state", 32'(bus.core_state), 7);
               check_val("done_flag", 32'(bus.done), 1);
               check_val("done_cycle", 32'(cycles), 32'(exp_cycles));
               check_val("done_mask", 32'(bus.active_mask), 0);
               break;
            end
            cur = nxt;
         end
         check_val("kernel_bounded", 32'(guard < 64), 1);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("held_start_state", 32'(bus.core_state), 7);
         check_val("held_start_done", 32'(bus.done), 1);
      end
      bus.start = 1'b0;
      tick();
      check_val("idle_state", 32'(bus.core_state), 0);
      check_val("idle_done", 32'(bus.done), 0);
      check_val("idle_mask", 32'(bus.active_mask), 0);
      $display("kernel tc=%0d mode=%0d warps=%0d cycles=%0d", tc, mode, wc, cycles);
   endtask

   task automatic reset_mid_kernel();
      bit reached;
      reached = 1'b0;
      bus.thread_count = 8'd8;
      bus.start = 1'b1;
      bus.instruction_ready = 1'b1;
      bus.decoded_done = 1'b0;
      bus.next_pc = {WS{8'h55}};
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.current_warp_id == 2'd1) bus.lsu_busy = '1;
         if (bus.core_state == 3'd4 && bus.current_warp_id == 2'd1) begin
            reached = 1'b1;
            break;
         end
      end
      check_val("reach_w1_wait", 32'(reached), 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_state", 32'(bus.core_state), 0);
      check_val("rst_fetch_en", 32'(bus.fetch_enable), 0);
      check_val("rst_warp", 32'(bus.current_warp_id), 0);
      check_val("rst_mask", 32'(bus.active_mask), 0);
      check_val("rst_done", 32'(bus.done), 0);
      check_val("rst_pc", 32'(bus.fetch_pc), 0);
      bus.start = 1'b0;
      bus.instruction_ready = 1'b0;
      bus.lsu_busy = '0;
      #1 rst_n = 1'b1;
      tick();
      check_val("post_rst_state", 32'(bus.core_state), 0);
      $display("reset pulsed during warp 1 WAIT");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.thread_count = '0;
      bus.instruction_ready = 1'b0;
      bus.decoded_done = 1'b0;
      bus.lsu_busy = '0;
      bus.next_pc = '0;
      repeat (3) @(negedge clk);
      check_val("reset_state", 32'(bus.core_state), 0);
      check_val("reset_fetch_en", 32'(bus.fetch_enable), 0);
      check_val("reset_done", 32'(bus.done), 0);
      check_val("reset_mask", 32'(bus.active_mask), 0);
      check_val("reset_warp", 32'(bus.current_warp_id), 0);
      check_val("reset_pc", 32'(bus.fetch_pc), 0);
      check_div();
      rst_n = 1'b1;
      tick();
      run_kernel(8, 0);
      run_kernel(6, 4);
      run_kernel(4, 2);
      run_kernel(2, 2);
      run_kernel(0, 0);
      run_kernel(20, 0);
      reset_mid_kernel();
      run_kernel(8, 1);
`ifdef DIVERGENCE_CHECK_EN
      run_kernel(4, 3);
`endif
      for (int r = 0; r < 12; r++) run_kernel($urandom_range(0, 24), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
